// File: rtl/ternary_pkg.sv
// Shared constants and types for the ternary matrix-vector front-end.
// Holds the weight encoding, derived geometry and the pair-collection phase type.
package ternary_pkg;

  localparam int unsigned IN_LEN    = 16;
  localparam int unsigned OUT_LEN   = 8;
  localparam int unsigned BIT_WIDTH = 8;

  localparam int unsigned NROWS   = IN_LEN / 2;
  localparam int unsigned ROW_W   = $clog2(NROWS);
  localparam int unsigned WBITS   = 2 * IN_LEN * OUT_LEN;
  localparam int unsigned NBYTES  = WBITS / 8;
  localparam int unsigned ADDR_W  = $clog2(NBYTES);
  localparam int unsigned SLICE_W = 4 * OUT_LEN;
  localparam int unsigned PAIR_W  = 2 * BIT_WIDTH;

  // Ternary weight codes (2'b10 also decodes as zero)
  localparam logic [1:0] TERN_POS  = 2'b01;
  localparam logic [1:0] TERN_NEG  = 2'b11;
  localparam logic [1:0] TERN_ZERO = 2'b00;

  // Which element of an activation pair the next RUN byte fills
  typedef enum logic {
    PH_HIGH = 1'b0,
    PH_LOW  = 1'b1
  } phase_e;

endpackage

// File: rtl/ternary_vec_sequencer_if.sv
// Pin-side and multiplier-side signal bundle of the ternary vector sequencer.
//   load_mode/in_valid/data_in : byte stream into the sequencer
//   vec_pair/row/w_slice       : operands presented to the multiplier
//   mult_en/frame_done         : operand-valid and last-row strobes
//   weights_ready              : full weight set present
// master drives the byte stream, slave is the sequencer.
interface ternary_vec_sequencer_if;
  import ternary_pkg::*;

  logic                 load_mode;
  logic                 in_valid;
  logic [BIT_WIDTH-1:0] data_in;
  logic [PAIR_W-1:0]    vec_pair;
  logic [ROW_W-1:0]     row;
  logic [SLICE_W-1:0]   w_slice;
  logic                 mult_en;
  logic                 frame_done;
  logic                 weights_ready;

  modport master (
    output load_mode, in_valid, data_in,
    input  vec_pair, row, w_slice, mult_en, frame_done, weights_ready
  );

  modport slave (
    input  load_mode, in_valid, data_in,
    output vec_pair, row, w_slice, mult_en, frame_done, weights_ready
  );

endinterface

// File: rtl/ternary_weight_bank.sv
// Ternary weight register file: byte-wide write port, registered row-wide read port.
//   clk, rst_n : clock, async active-low reset (clears storage and read register)
//   we_i/waddr_i/wdata_i : byte write, byte k lands in bits [8k+7:8k]
//   re_i/raddr_i         : row read request, rdata_o updates only when re_i is high
//   rdata_o              : 32-bit row slice, held between reads
module ternary_weight_bank
  import ternary_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    waddr_i,
  input  logic [7:0]           wdata_i,
  input  logic                 re_i,
  input  logic [ROW_W-1:0]     raddr_i,
  output logic [SLICE_W-1:0]   rdata_o
);

  logic [WBITS-1:0]   mem_q;
  logic [SLICE_W-1:0] rdata_q;

  // Storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (we_i) begin
      mem_q[{waddr_i, 3'b000} +: 8] <= wdata_i;
    end
  end

  // Row read register; holds its value between read requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[{raddr_i, 5'b00000} +: SLICE_W];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ternary_vec_sequencer.sv
// Front-end of the ternary matrix-vector multiplier.
// LOAD mode deserialises bytes into the weight bank; RUN mode pairs activation
// bytes and presents {vec_pair, row, w_slice} with a one-cycle mult_en strobe.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of ternary_vec_sequencer_if
module ternary_vec_sequencer
  import ternary_pkg::*;
(
  input logic                    clk,
  input logic                    rst_n,
  ternary_vec_sequencer_if.slave bus
);

  phase_e               phase_q,      phase_d;
  logic [ROW_W-1:0]     row_cnt_q,    row_cnt_d;
  logic [BIT_WIDTH-1:0] high_q,       high_d;
  logic [ADDR_W-1:0]    wptr_q,       wptr_d;
  logic                 ready_q,      ready_d;
  logic [PAIR_W-1:0]    vec_pair_q,   vec_pair_d;
  logic [ROW_W-1:0]     row_q,        row_d;
  logic                 mult_en_q,    mult_en_d;
  logic                 frame_done_q, frame_done_d;
  logic                 bank_we;
  logic                 bank_re;
  logic [SLICE_W-1:0]   bank_rdata;

  ternary_weight_bank u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (bank_we),
    .waddr_i (wptr_q),
    .wdata_i (bus.data_in),
    .re_i    (bank_re),
    .raddr_i (row_cnt_q),
    .rdata_o (bank_rdata)
  );

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= PH_HIGH;
      row_cnt_q    <= '0;
      high_q       <= '0;
      wptr_q       <= '0;
      ready_q      <= 1'b0;
      vec_pair_q   <= '0;
      row_q        <= '0;
      mult_en_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      row_cnt_q    <= row_cnt_d;
      high_q       <= high_d;
      wptr_q       <= wptr_d;
      ready_q      <= ready_d;
      vec_pair_q   <= vec_pair_d;
      row_q        <= row_d;
      mult_en_q    <= mult_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state: LOAD writes the bank; RUN collects pairs and emits one row per pair.
  // Holding phase/row_cnt at zero throughout LOAD discards any half pair on a mode change.
  always_comb begin
    phase_d      = phase_q;
    row_cnt_d    = row_cnt_q;
    high_d       = high_q;
    wptr_d       = wptr_q;
    ready_d      = ready_q;
    vec_pair_d   = vec_pair_q;
    row_d        = row_q;
    mult_en_d    = 1'b0;
    frame_done_d = 1'b0;
    bank_we      = 1'b0;
    bank_re      = 1'b0;

    if (bus.load_mode) begin
      phase_d   = PH_HIGH;
      row_cnt_d = '0;
      if (bus.in_valid) begin
        bank_we = 1'b1;
        wptr_d  = wptr_q + ADDR_W'(1);
        if (wptr_q == '0) begin
          ready_d = 1'b0;
        end else if (wptr_q == ADDR_W'(NBYTES - 1)) begin
          ready_d = 1'b1;
        end
      end
    end else if (bus.in_valid && ready_q) begin
      case (phase_q)
        PH_HIGH: begin
          high_d  = bus.data_in;
          phase_d = PH_LOW;
        end
        PH_LOW: begin
          vec_pair_d   = {high_q, bus.data_in};
          row_d        = row_cnt_q;
          bank_re      = 1'b1;
          mult_en_d    = 1'b1;
          frame_done_d = (row_cnt_q == ROW_W'(NROWS - 1));
          row_cnt_d    = row_cnt_q + ROW_W'(1);
          phase_d      = PH_HIGH;
        end
        default: phase_d = PH_HIGH;
      endcase
    end
  end

  assign bus.vec_pair      = vec_pair_q;
  assign bus.row           = row_q;
  assign bus.w_slice       = bank_rdata;
  assign bus.mult_en       = mult_en_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.weights_ready = ready_q;

endmodule

// File: tb/tb_ternary_vec_sequencer.sv
// Directed self-checking bench for ternary_vec_sequencer.
module tb_ternary_vec_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ternary_vec_sequencer_if bus ();

  ternary_vec_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs were set before, outputs are stable afterwards
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic lm, input logic [7:0] d);
    bus.load_mode = lm;
    bus.in_valid  = 1'b1;
    bus.data_in   = d;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  // Load 32 bytes, byte k = base + k
  task automatic load_all(input logic [7:0] base);
    for (int k = 0; k < 32; k++) send_byte(1'b1, 8'(int'(base) + k));
    bus.load_mode = 1'b0;
  endtask

  function automatic logic [31:0] exp_slice(input int base, input int r);
    return {8'(base + 4*r + 3), 8'(base + 4*r + 2), 8'(base + 4*r + 1), 8'(base + 4*r)};
  endfunction

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] prev;
    checks        = 0;
    failures      = 0;
    prev          = '0;
    rst_n         = 1'b0;
    bus.load_mode = 1'b0;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    #1;
    chk("rst_mult_en", 32'(bus.mult_en), 32'h0);
    chk("rst_vec_pair", 32'(bus.vec_pair), 32'h0);
    chk("rst_w_slice", bus.w_slice, 32'h0);
    chk("rst_ready", 32'(bus.weights_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Run bytes before any load are dropped
    send_byte(1'b0, 8'h10);
    send_byte(1'b0, 8'h20);
    chk("noload_mult_en", 32'(bus.mult_en), 32'h0);
    send_byte(1'b0, 8'h30);
    send_byte(1'b0, 8'h40);
    chk("noload_mult_en2", 32'(bus.mult_en), 32'h0);
    chk("noload_row", 32'(bus.row), 32'h0);

    // Basic load then one pair
    for (int k = 0; k < 31; k++) send_byte(1'b1, 8'(k));
    chk("ready_before_last", 32'(bus.weights_ready), 32'h0);
    send_byte(1'b1, 8'h1F);
    chk("ready_after_last", 32'(bus.weights_ready), 32'h1);
    bus.load_mode = 1'b0;
    send_byte(1'b0, 8'h05);
    chk("t1_no_strobe_first", 32'(bus.mult_en), 32'h0);
    send_byte(1'b0, 8'hFB);
    chk("t1_mult_en", 32'(bus.mult_en), 32'h1);
    chk("t1_vec_pair", 32'(bus.vec_pair), 32'h05FB);
    chk("t1_row", 32'(bus.row), 32'h0);
    chk("t1_w_slice", bus.w_slice, 32'h03020100);
    chk("t1_frame_done", 32'(bus.frame_done), 32'h0);
    tick();
    chk("t1_strobe_drop", 32'(bus.mult_en), 32'h0);
    chk("t1_pair_hold", 32'(bus.vec_pair), 32'h05FB);

    // Full frame, no gaps, with a fresh weight set
    load_all(8'h40);
    chk("t2_ready", 32'(bus.weights_ready), 32'h1);
    for (int i = 0; i < 18; i++) begin
      d = 8'(16 + 3*i);
      send_byte(1'b0, d);
      if (i % 2 == 1) begin
        chk("t2_mult_en", 32'(bus.mult_en), 32'h1);
        chk("t2_row", 32'(bus.row), 32'((i/2) % 8));
        chk("t2_frame_done", 32'(bus.frame_done), (i/2 == 7) ? 32'h1 : 32'h0);
        chk("t2_vec_pair", 32'(bus.vec_pair), 32'({prev, d}));
        chk("t2_w_slice", bus.w_slice, exp_slice(8'h40, (i/2) % 8));
      end else begin
        chk("t2_gap_mult_en", 32'(bus.mult_en), 32'h0);
      end
      prev = d;
    end

    // Half pair discarded by a load_mode toggle
    send_byte(1'b0, 8'h33);
    bus.load_mode = 1'b1;
    tick();
    bus.load_mode = 1'b0;
    tick();
    send_byte(1'b0, 8'h11);
    chk("t4_no_stale_pair", 32'(bus.mult_en), 32'h0);
    send_byte(1'b0, 8'h22);
    chk("t4_mult_en", 32'(bus.mult_en), 32'h1);
    chk("t4_vec_pair", 32'(bus.vec_pair), 32'h1122);
    chk("t4_row", 32'(bus.row), 32'h0);
    chk("t4_w_slice", bus.w_slice, 32'h43424140);

    // Reset mid-frame at row_cnt 5
    for (int i = 0; i < 8; i++) send_byte(1'b0, 8'(i));
    chk("t5_row_before", 32'(bus.row), 32'h4);
    send_byte(1'b0, 8'h77);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_row", 32'(bus.row), 32'h0);
    chk("t5_rst_pair", 32'(bus.vec_pair), 32'h0);
    chk("t5_rst_slice", bus.w_slice, 32'h0);
    chk("t5_rst_ready", 32'(bus.weights_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    send_byte(1'b0, 8'h01);
    send_byte(1'b0, 8'h02);
    chk("t5_dropped", 32'(bus.mult_en), 32'h0);
    load_all(8'h80);
    send_byte(1'b0, 8'h5A);
    send_byte(1'b0, 8'hA5);
    chk("t5_mult_en", 32'(bus.mult_en), 32'h1);
    chk("t5_row0", 32'(bus.row), 32'h0);
    chk("t5_w_slice", bus.w_slice, 32'h83828180);

    // 33rd byte restarts the load at byte 0
    send_byte(1'b1, 8'hAA);
    chk("t6_ready_fall", 32'(bus.weights_ready), 32'h0);
    for (int k = 1; k < 31; k++) send_byte(1'b1, 8'(8'h80 + k));
    chk("t6_ready_low", 32'(bus.weights_ready), 32'h0);
    send_byte(1'b1, 8'h9F);
    chk("t6_ready_rise", 32'(bus.weights_ready), 32'h1);
    bus.load_mode = 1'b0;
    send_byte(1'b0, 8'h01);
    send_byte(1'b0, 8'h02);
    chk("t6_mult_en", 32'(bus.mult_en), 32'h1);
    chk("t6_w_slice", bus.w_slice, 32'h838281AA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
